sram_controller: RTL

- Bridges the ARM core's MEM stage (32-bit word read/write) to the external 16-bit asynchronous-style SRAM.
- Each word access is split into two half-word SRAM accesses, low half first, with configurable wait states.
- Drives the SRAM control pins and the bidirectional data bus.
- Deasserts `ready` while an access is in flight; the core uses this as its pipeline freeze.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the 32-bit core to 16-bit SRAM bridge.
package sram_ctrl_pkg;

    localparam int DATA_W      = 32;
    localparam int SRAM_DQ_W   = 16;
    localparam int SRAM_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    // Word index within the SRAM; addresses below the base wrap silently.
    function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [DATA_W-1:0] addr,
                                                          input logic [DATA_W-1:0] base);
        return (SRAM_ADDR_W-1)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit core access into two half-word SRAM accesses (low half first),
// each phase stretched by WAIT_CYCLES extra clocks.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [DATA_W-1:0]      address,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data,
    output logic                   ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [DATA_W-1:0] BASE     = DATA_W'(ADDR_BASE);

    state_t                   state_reg;
    op_t                      op_reg;
    logic [CNT_W-1:0]         wait_cnt_reg;
    logic [SRAM_ADDR_W-2:0]   word_reg;
    logic [SRAM_DQ_W-1:0]     hi_data_reg;
    logic [SRAM_DQ_W-1:0]     dq_out_reg;
    logic                     drive_en_reg;
    logic [DATA_W-1:0]        read_data_reg;
    logic [SRAM_ADDR_W-1:0]   sram_addr_reg;
    logic                     ce_n_reg;
    logic                     byte_en_n_reg;
    logic                     we_n_reg;
    logic                     oe_n_reg;

    logic                     phase_last;
    logic [SRAM_ADDR_W-2:0]   req_word;

    assign phase_last = (wait_cnt_reg == CNT_LAST);
    assign req_word   = word_index(address, BASE);

    // Pin values are loaded together with the state they belong to, so every
    // SRAM control output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            op_reg        <= OP_READ;
            wait_cnt_reg  <= '0;
            word_reg      <= '0;
            hi_data_reg   <= '0;
            dq_out_reg    <= '0;
            drive_en_reg  <= 1'b0;
            read_data_reg <= '0;
            sram_addr_reg <= '0;
            ce_n_reg      <= 1'b1;
            byte_en_n_reg <= 1'b1;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        op_reg        <= wr_en ? OP_WRITE : OP_READ;
                        word_reg      <= req_word;
                        hi_data_reg   <= write_data[DATA_W-1:SRAM_DQ_W];
                        dq_out_reg    <= write_data[SRAM_DQ_W-1:0];
                        drive_en_reg  <= wr_en;
                        sram_addr_reg <= {req_word, 1'b0};
                        ce_n_reg      <= 1'b0;
                        byte_en_n_reg <= 1'b0;
                        we_n_reg      <= !wr_en;
                        oe_n_reg      <= wr_en;
                        wait_cnt_reg  <= '0;
                        state_reg     <= LOW;
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        if (op_reg == OP_READ) begin
                            read_data_reg[SRAM_DQ_W-1:0] <= SRAM_DQ;
                        end
                        dq_out_reg    <= hi_data_reg;
                        sram_addr_reg <= {word_reg, 1'b1};
                        wait_cnt_reg  <= '0;
                        state_reg     <= HIGH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        if (op_reg == OP_READ) begin
                            read_data_reg[DATA_W-1:SRAM_DQ_W] <= SRAM_DQ;
                        end
                        drive_en_reg  <= 1'b0;
                        ce_n_reg      <= 1'b1;
                        byte_en_n_reg <= 1'b1;
                        we_n_reg      <= 1'b1;
                        oe_n_reg      <= 1'b1;
                        wait_cnt_reg  <= '0;
                        state_reg     <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready     = !(wr_en || rd_en) || (state_reg == DONE);
    assign read_data = read_data_reg;
    assign SRAM_DQ   = drive_en_reg ? dq_out_reg : 'z;
    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_CE_N = ce_n_reg;
    assign SRAM_UB_N = byte_en_n_reg;
    assign SRAM_LB_N = byte_en_n_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;

endmodule
